// File: rtl/execute_stage_pkg.sv
// Shared pipeline types for the RV64 execute stage: decoded control, stage payloads,
// and the iterative multiply/divide state encoding.
package execute_stage_pkg;

  localparam int unsigned XLEN             = 64;
  localparam int unsigned MD_ITERS_DEFAULT = 64;

  typedef enum logic [4:0] {
    ALU_NOTALU,
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_LUI,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_MULT,
    ALU_DIV,
    ALU_REM,
    ALU_DIVU,
    ALU_REMU
  } alufunc_t;

  typedef enum logic [3:0] {
    OP_ALU,
    OP_ALUI,
    OP_ALUW,
    OP_ALUIW,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_JAL,
    OP_JALR,
    OP_LUI,
    OP_AUIPC
  } decoded_op_t;

  typedef struct packed {
    decoded_op_t op;
    alufunc_t    alufunc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
  } control_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     raw_instr;
    control_t        ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] rd2;
  } decode_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     raw_instr;
    control_t        ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rd2;
  } excute_data_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  // Relies on the multiply/divide functions being the contiguous tail of alufunc_t.
  function automatic logic is_muldiv(alufunc_t f);
    return (f >= ALU_MULT) && (f <= ALU_REMU);
  endfunction

  function automatic logic is_word_op(decoded_op_t op);
    return (op == OP_ALUW) || (op == OP_ALUIW);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage boundary: D/E payload in, E/M payload and hazard stall out.
interface execute_stage_if;
  import execute_stage_pkg::*;

  decode_data_t dataD;
  logic         flush;
  logic         stallM;
  excute_data_t dataE;
  logic         stall_req;

  modport master (output dataD, flush, stallM, input dataE, stall_req);
  modport slave  (input dataD, flush, stallM, output dataE, stall_req);

endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative RV64 multiply/divide: one shift-add or restoring-division step per cycle,
// with sign, divide-by-zero and W-form fixups applied on the final step.
module execute_stage_muldiv_unit
  import execute_stage_pkg::*;
#(
  parameter int unsigned ITERS = MD_ITERS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic             hold,
  input  logic [XLEN-1:0]  srca,
  input  logic [XLEN-1:0]  srcb,
  input  alufunc_t         alufunc,
  input  logic             w,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result
);

  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  md_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] dividend_q;
  alufunc_t        func_q;
  logic            w_q;
  logic            negq_q;
  logic            negr_q;
  logic            dbz_q;

  logic            signed_op;
  logic            sext_op;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  // Operand preparation at acceptance
  always_comb begin
    signed_op = (alufunc == ALU_DIV) || (alufunc == ALU_REM);
    sext_op   = signed_op || (alufunc == ALU_MULT);
    a_ext     = srca;
    b_ext     = srcb;
    if (w) begin
      a_ext = sext_op ? {{32{srca[31]}}, srca[31:0]} : {32'b0, srca[31:0]};
      b_ext = sext_op ? {{32{srcb[31]}}, srcb[31:0]} : {32'b0, srcb[31:0]};
    end
    a_neg = signed_op & a_ext[XLEN-1];
    b_neg = signed_op & b_ext[XLEN-1];
    a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
    b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;
  end

  logic [XLEN-1:0] mul_acc;
  logic [XLEN:0]   rshift;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] raw_res;
  logic [XLEN-1:0] fin_res;

  // One iteration step plus the result the final step would commit
  always_comb begin
    mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
    rshift  = {acc_q, opa_q[XLEN-1]};
    diff    = rshift - {1'b0, opb_q};
    ge      = ~diff[XLEN];
    div_rem = ge ? diff[XLEN-1:0] : rshift[XLEN-1:0];
    div_quo = {opa_q[XLEN-2:0], ge};
    quo_fix = dbz_q ? '1 : (negq_q ? (~div_quo + 64'd1) : div_quo);
    rem_fix = dbz_q ? dividend_q : (negr_q ? (~div_rem + 64'd1) : div_rem);
    case (func_q)
      ALU_MULT:          raw_res = mul_acc;
      ALU_DIV, ALU_DIVU: raw_res = quo_fix;
      default:           raw_res = rem_fix;
    endcase
    fin_res = w_q ? {{32{raw_res[31]}}, raw_res[31:0]} : raw_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      dividend_q <= '0;
      func_q     <= ALU_NOTALU;
      w_q        <= 1'b0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      dbz_q      <= 1'b0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (flush) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_q    <= MD_BUSY;
            busy       <= 1'b1;
            cnt_q      <= '0;
            func_q     <= alufunc;
            w_q        <= w;
            acc_q      <= '0;
            dividend_q <= a_ext;
            negq_q     <= a_neg ^ b_neg;
            negr_q     <= a_neg;
            dbz_q      <= (b_ext == '0);
            // Multiply runs on the raw two's-complement operands; divide on magnitudes
            opa_q      <= (alufunc == ALU_MULT) ? a_ext : a_mag;
            opb_q      <= (alufunc == ALU_MULT) ? b_ext : b_mag;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (func_q == ALU_MULT) begin
            acc_q <= mul_acc;
            opa_q <= {opa_q[XLEN-2:0], 1'b0};
            opb_q <= {1'b0, opb_q[XLEN-1:1]};
          end else begin
            acc_q <= div_rem;
            opa_q <= div_quo;
          end
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            state_q <= MD_DONE;
            result  <= fin_res;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        MD_DONE: begin
          if (!hold) begin
            state_q <= MD_IDLE;
            done    <= 1'b0;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// RV64 execute stage: combinational ALU, iterative mul/div sub-unit, output mux and
// front-end stall request.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned MD_ITERS = MD_ITERS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  execute_stage_if.slave  bus
);

  decode_data_t    d;
  logic            w;
  logic            md_op;
  logic            md_start;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] alu_out;
  logic [5:0]      sh;
  logic [31:0]     a32;
  excute_data_t    e;

  assign d        = bus.dataD;
  assign w        = is_word_op(d.ctl.op);
  assign md_op    = is_muldiv(d.ctl.alufunc);
  assign md_start = d.valid & md_op & ~bus.flush;

  // Single-cycle ALU; W forms use 5-bit shift amounts and sign-extend bit 31
  always_comb begin
    alu_res = '0;
    sh      = w ? {1'b0, d.srcb[4:0]} : d.srcb[5:0];
    a32     = d.srca[31:0];
    case (d.ctl.alufunc)
      ALU_ADD, ALU_NOTALU: alu_res = d.srca + d.srcb;
      ALU_SUB:  alu_res = d.srca - d.srcb;
      ALU_XOR:  alu_res = d.srca ^ d.srcb;
      ALU_OR:   alu_res = d.srca | d.srcb;
      ALU_AND:  alu_res = d.srca & d.srcb;
      ALU_LUI:  alu_res = d.srcb;
      ALU_SLT:  alu_res = {63'b0, $signed(d.srca) < $signed(d.srcb)};
      ALU_SLTU: alu_res = {63'b0, d.srca < d.srcb};
      ALU_SLL:  alu_res = w ? {32'b0, a32 << sh[4:0]} : d.srca << sh;
      ALU_SRL:  alu_res = w ? {32'b0, a32 >> sh[4:0]} : d.srca >> sh;
      ALU_SRA:  alu_res = w ? {32'b0, 32'($signed(a32) >>> sh[4:0])}
                            : 64'($signed(d.srca) >>> sh);
      default:  alu_res = '0;
    endcase
    alu_out = w ? {{32{alu_res[31]}}, alu_res[31:0]} : alu_res;
  end

  execute_stage_muldiv_unit #(
    .ITERS (MD_ITERS)
  ) u_muldiv_unit (
    .clk     (clk),
    .rst_n   (reset),
    .start   (md_start),
    .flush   (bus.flush),
    .hold    (bus.stallM),
    .srca    (d.srca),
    .srcb    (d.srcb),
    .alufunc (d.ctl.alufunc),
    .w       (w),
    .busy    (md_busy),
    .done    (md_done),
    .result  (md_result)
  );

  // Stall covers the accepting cycle plus every busy cycle; released once the result shows
  assign bus.stall_req = (~md_busy & ~md_done & md_start) | md_busy;

  always_comb begin
    e           = '0;
    e.pc        = d.pc;
    e.raw_instr = d.raw_instr;
    e.ctl       = d.ctl;
    e.dst       = d.dst;
    e.rd2       = d.rd2;
    e.result    = md_op ? md_result : alu_out;
    e.valid     = d.valid & ~bus.flush & (~md_op | md_done);
  end

  assign bus.dataE = e;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV64 pipeline; sits between the decode/execute pipeline register and the execute/memory register.
- Consumes `decode_data_t` and produces `excute_data_t`.
- Single-cycle ALU ops are combinational. MUL/DIV/REM/DIVU/REMU (and W forms) run in an iterative multi-cycle unit, which stalls the front end until the result is ready.

Parameters:
- MD_ITERS, 64, iterations per multiply/divide operation (one bit per cycle).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- dataD  in  decode_data_t  instruction from the D/E register; held stable by upstream while stall_req=1
- flush  in  1  kill the current E instruction (branch/jump redirect)
- stallM  in  1  downstream cannot accept this cycle
- dataE  out  excute_data_t  result toward the E/M register
- stall_req  out  1  to hazard unit; freeze F/D/E registers

Behaviour:
- Output passthrough: dataE.pc, raw_instr, ctl, dst and rd2 come from dataD unchanged.
- Output valid (non-muldiv): dataE.valid = dataD.valid & ~flush, same cycle.
- Output valid (muldiv): dataE.valid = dataD.valid & ~flush & (state==DONE).
- W ops (ctl.op is ALUW or ALUIW): compute on 32 bits, then sign-extend bit 31 into result[63:32].
- ALU result by alufunc, 64-bit form unless W:
  - ADD: srca+srcb
  - SUB: srca-srcb
  - XOR / OR / AND: bitwise
  - LUI: srcb
  - SLT / SLTU: signed / unsigned compare, result 0 or 1
  - SLL / SRL / SRA: shift amount is srcb[5:0] (srcb[4:0] for W)
  - NOTALU: srca+srcb (address and link paths)
- Muldiv ops (MULT, DIV, REM, DIVU, REMU) go through an FSM with states IDLE, BUSY, DONE.
- IDLE:
  - dataD.valid & muldiv op & ~flush: latch operands, clear the iteration counter, go to BUSY.
  - stall_req=1 in this cycle.
- BUSY:
  - One iteration per cycle; the counter increments.
  - When counter==MD_ITERS-1, go to DONE.
  - stall_req=1 throughout.
- DONE:
  - Registered result drives dataE.result; stall_req=0.
  - If ~stallM, return to IDLE next cycle.
  - If stallM, hold DONE and keep the result stable.
- Latency: accepted at cycle 0, result visible at cycle MD_ITERS+1 (65). stall_req is high for exactly 65 cycles.
- Operand extension:
  - Signed W ops: sign-extend operand[31:0].
  - Unsigned W ops: zero-extend operand[31:0].
  - The 64-bit operation is then performed and the low 32 bits are sign-extended.
- Multiply: shift-add, keeping the low 64 bits of the product.
- Divide: restoring division on magnitudes, with sign fixup afterwards. Remainder takes the dividend's sign.
- Divide by zero:
  - quotient = all ones
  - remainder = dividend (for W ops: dividend[31:0], sign-extended)
  - The op still takes the full 65 cycles.
- Signed overflow (MIN / -1):
  - quotient = MIN, remainder = 0.
  - For DIVW, 0x80000000 / 0xFFFFFFFF gives 0xFFFFFFFF80000000.
- Flush in any state: FSM goes to IDLE next edge; any partial result is discarded; dataE.valid=0 that cycle.
- Reset (asynchronous, including mid-operation):
  - state=IDLE; counter, operand, partial and result registers = 0.
  - With dataD.valid=0, dataE.valid=0 and stall_req=0.
- dataD.valid=0 while in IDLE: FSM stays in IDLE and stall_req=0.

Decomposition:
- Additions to the shared pipes package:
  - `md_state_t` enum {MD_IDLE, MD_BUSY, MD_DONE}
  - MD_ITERS default constant
  - `is_muldiv` helper covering ALU_MULT through ALU_REMU
- One sub-module, `muldiv_unit`:
  - Inputs: operands, alufunc, W flag, start, flush.
  - Outputs: done, result.
  - Contains the FSM, counter and datapath.
- `execute_stage` keeps the combinational ALU, the output muxing and stall_req.

Test Plan:
- ADD 5+7, valid, no muldiv -> same cycle: dataE.result=12, valid=1, stall_req=0.
- DIV 20/-3 -> stall_req high cycles 0..64; cycle 65: result=0xFFFFFFFFFFFFFFFA, valid=1.
- REM 20/-3 -> 2.
- DIVU x/0 -> quotient 0xFFFFFFFFFFFFFFFF.
- REMU 9/0 -> 9.
- DIV 0x8000000000000000/-1 -> 0x8000000000000000.
- REM of the same operands -> 0.
- MULW 0x10000/0x10000 -> 0 (low 32 bits are zero).
- MULW 0x7FFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE.
- DIV started, flush at cycle 30 -> cycle 31: state IDLE, dataE.valid=0.
- DIV started, reset asserted at cycle 40 -> asynchronous return to IDLE, registers 0.
- DIV done with stallM=1 for 3 cycles -> FSM stays in DONE and the result is held; IDLE on the cycle after stallM falls.
